// File: rtl/hbridge_driver_if.sv
// Setpoint/mode inputs and pad outputs of hbridge_driver.
// The slave modport is the driver side.
interface hbridge_driver_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 8
);
  logic                enable;
  logic [NUM_CH*W-1:0] setpoint;
  logic [NUM_CH*2-1:0] mode;
  logic [NUM_CH-1:0]   pwm_a;
  logic [NUM_CH-1:0]   pwm_b;
  logic [NUM_CH-1:0]   at_target;
  logic                period_start;

  modport master (
    output enable, setpoint, mode,
    input  pwm_a, pwm_b, at_target, period_start
  );

  modport slave (
    input  enable, setpoint, mode,
    output pwm_a, pwm_b, at_target, period_start
  );
endinterface

// File: rtl/hbridge_driver.sv
// Multi-channel sign-magnitude H-bridge PWM driver with shared period
// counter, slew limiting, brake/coast modes and class-change dead time.
module hbridge_driver #(
  parameter int NUM_CH    = 2,
  parameter int W         = 8,
  parameter int DEADTIME  = 4,
  parameter int SLEW_STEP = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  hbridge_driver_if.slave bus
);

  typedef enum logic [1:0] {
    CL_OFF,
    CL_A,
    CL_B,
    CL_BRK
  } cls_e;

  localparam logic [W-1:0] CNT_LAST = '1;
  localparam logic [W-1:0] DT       = W'(DEADTIME);
  localparam logic [W:0]   STEP     = (W+1)'(SLEW_STEP);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SAT_NEG  = {1'b1, {(W-2){1'b0}}, 1'b1};

  logic [W-1:0]      cnt;
  logic [W-1:0]      act [NUM_CH];
  cls_e              cls [NUM_CH];
  logic [NUM_CH-1:0] dt;
  logic [NUM_CH-1:0] pa_q;
  logic [NUM_CH-1:0] pb_q;
  logic [NUM_CH-1:0] at_q;
  logic              ps_q;

  logic [W-1:0]      tgt  [NUM_CH];
  logic [W-1:0]      nact [NUM_CH];
  logic [W-1:0]      mag  [NUM_CH];
  logic [W-1:0]      cmp  [NUM_CH];
  logic [W:0]        diff [NUM_CH];
  logic [W:0]        dmag [NUM_CH];
  cls_e              ncls [NUM_CH];
  logic [NUM_CH-1:0] drv;
  logic [NUM_CH-1:0] brk;
  logic [NUM_CH-1:0] ndt;
  logic [NUM_CH-1:0] on;
  logic [NUM_CH-1:0] dead;
  logic [NUM_CH-1:0] pa_n;
  logic [NUM_CH-1:0] pb_n;
  logic [NUM_CH-1:0] at_n;
  logic [NUM_CH-1:0] tz;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      drv[i] = bus.mode[2*i +: 2] == 2'b01;
      brk[i] = bus.mode[2*i +: 2] == 2'b10;
      tgt[i] = bus.setpoint[W*i +: W];
      if (tgt[i] == MOST_NEG) tgt[i] = SAT_NEG;
      tz[i] = tgt[i] == '0;

      // W+1 bits keeps tgt-act exact across the full signed range
      diff[i] = {tgt[i][W-1], tgt[i]} - {act[i][W-1], act[i]};
      dmag[i] = diff[i][W] ? -diff[i] : diff[i];
      nact[i] = '0;
      if (drv[i]) begin
        if (SLEW_STEP == 0 || dmag[i] <= STEP)
          nact[i] = tgt[i];
        else if (diff[i][W])
          nact[i] = act[i] - STEP[W-1:0];
        else
          nact[i] = act[i] + STEP[W-1:0];
      end

      if (brk[i])
        ncls[i] = CL_BRK;
      else if (nact[i] == '0)
        ncls[i] = CL_OFF;
      else if (nact[i][W-1])
        ncls[i] = CL_B;
      else
        ncls[i] = CL_A;
      ndt[i] = ncls[i] != CL_OFF && cls[i] != CL_OFF
               && ncls[i] != cls[i];

      mag[i]  = act[i][W-1] ? -act[i] : act[i];
      cmp[i]  = mag[i] << 1;
      on[i]   = cnt < cmp[i];
      dead[i] = dt[i] && cnt < DT;
      pa_n[i] = 1'b0;
      pb_n[i] = 1'b0;
      unique case (cls[i])
        CL_A:    pa_n[i] = on[i] & ~dead[i];
        CL_B:    pb_n[i] = on[i] & ~dead[i];
        CL_BRK: begin
          pa_n[i] = ~dead[i];
          pb_n[i] = ~dead[i];
        end
        default: ;
      endcase

      at_n[i] = drv[i] ? act[i] == tgt[i] : tz[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      ps_q <= 1'b0;
      pa_q <= '0;
      pb_q <= '0;
      dt   <= '0;
      at_q <= tz;
      for (int i = 0; i < NUM_CH; i++) begin
        act[i] <= '0;
        cls[i] <= CL_OFF;
      end
    end else begin
      cnt  <= cnt + 1'b1;
      ps_q <= cnt == '0;
      at_q <= at_n;
      if (!bus.enable) begin
        pa_q <= '0;
        pb_q <= '0;
        dt   <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          act[i] <= '0;
          cls[i] <= CL_OFF;
        end
      end else begin
        pa_q <= pa_n;
        pb_q <= pb_n;
        if (cnt == CNT_LAST) begin
          dt <= ndt;
          for (int i = 0; i < NUM_CH; i++) begin
            act[i] <= nact[i];
            cls[i] <= ncls[i];
          end
        end
      end
    end
  end

  assign bus.pwm_a        = pa_q;
  assign bus.pwm_b        = pb_q;
  assign bus.at_target    = at_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed bench: a no-slew and a slew-limited hbridge_driver, checked
// period by period against hand-computed pulse counts.
module tb_hbridge_driver;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tcnt;
  logic [7:0] ocnt;
  int total = 0;
  int bad = 0;

  int na  [2][2];
  int nb  [2][2];
  int nab [2][2];
  int fst [2][2];
  int atq [2][2];
  int nps [2];
  int ps0 [2];
  int n;
  int exp_a [7] = '{32, 64, 96, 128, 160, 192, 200};

  typedef struct {
    string      nm;
    logic       en;
    logic [1:0] m0;
    logic [7:0] s0;
    logic [1:0] m1;
    logic [7:0] s1;
    int a0, b0, ab0, f0, t0;
    int a1, b1, ab1, f1, t1;
  } vec_t;

  vec_t vt [13];

  hbridge_driver_if #(.NUM_CH(2), .W(8)) bus0 ();
  hbridge_driver_if #(.NUM_CH(2), .W(8)) bus1 ();

  hbridge_driver dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  hbridge_driver #(.SLEW_STEP(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  // expected DUT counter; outputs seen after an edge reflect ocnt
  always @(posedge clk)
    if (!reset_n) tcnt <= 8'd0;
    else          tcnt <= tcnt + 8'd1;
  assign ocnt = tcnt - 8'd1;

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic goto(int k);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (ocnt != 8'(k) && g < 300);
    if (ocnt != 8'(k)) chk("goto", int'(ocnt), k);
  endtask

  task automatic sample(int k);
    logic [1:0] a [2];
    logic [1:0] b [2];
    logic [1:0] t [2];
    logic       p [2];
    a[0] = bus0.pwm_a; b[0] = bus0.pwm_b;
    t[0] = bus0.at_target; p[0] = bus0.period_start;
    a[1] = bus1.pwm_a; b[1] = bus1.pwm_b;
    t[1] = bus1.at_target; p[1] = bus1.period_start;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (a[d][c]) na[d][c]++;
        if (b[d][c]) nb[d][c]++;
        if (a[d][c] && b[d][c]) nab[d][c]++;
        if ((a[d][c] || b[d][c]) && fst[d][c] < 0) fst[d][c] = k;
        if (k == 255) atq[d][c] = int'(t[d][c]);
      end
      if (p[d]) nps[d]++;
      if (p[d] && k == 0) ps0[d] = 1;
    end
  endtask

  task automatic measure();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        na[d][c] = 0; nb[d][c] = 0; nab[d][c] = 0;
        fst[d][c] = -1; atq[d][c] = -1;
      end
      nps[d] = 0;
      ps0[d] = 0;
    end
    goto(0);
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      sample(k);
    end
  endtask

  task automatic count_rest(int last, output int cnt_hi);
    int g;
    g = 0;
    cnt_hi = 0;
    do begin
      @(negedge clk);
      g++;
      if (bus0.pwm_a[0] || bus0.pwm_b[0]) cnt_hi++;
    end while (ocnt != 8'(last) && g < 300);
  endtask

  task automatic check_ch(string nm, int d, int c,
                          int ea, int eb, int eab, int ef, int et);
    chk($sformatf("%s.d%0d.ch%0d.a", nm, d, c), na[d][c], ea);
    chk($sformatf("%s.d%0d.ch%0d.b", nm, d, c), nb[d][c], eb);
    chk($sformatf("%s.d%0d.ch%0d.ab", nm, d, c), nab[d][c], eab);
    chk($sformatf("%s.d%0d.ch%0d.first", nm, d, c), fst[d][c], ef);
    chk($sformatf("%s.d%0d.ch%0d.at", nm, d, c), atq[d][c], et);
  endtask

  task automatic check_ps(string nm, int d);
    chk($sformatf("%s.d%0d.ps_count", nm, d), nps[d], 1);
    chk($sformatf("%s.d%0d.ps_at0", nm, d), ps0[d], 1);
  endtask

  task automatic set0(logic en, logic [1:0] m0, logic [7:0] s0,
                      logic [1:0] m1, logic [7:0] s1);
    bus0.enable   = en;
    bus0.mode     = {m1, m0};
    bus0.setpoint = {s1, s0};
  endtask

  initial begin
    vt[0]  = '{"ch1_sat", 1'b1, 2'b01, 8'hC0, 2'b01, 8'h80,
               0, 128, 0, 0, 1, 0, 254, 0, 0, 1};
    vt[1]  = '{"ch1_brk_dt", 1'b1, 2'b01, 8'hC0, 2'b10, 8'h80,
               0, 128, 0, 0, 1, 252, 252, 252, 4, 0};
    vt[2]  = '{"ch1_brk", 1'b1, 2'b01, 8'hC0, 2'b10, 8'h80,
               0, 128, 0, 0, 1, 256, 256, 256, 0, 0};
    vt[3]  = '{"coast", 1'b1, 2'b11, 8'h00, 2'b00, 8'h7F,
               0, 0, 0, -1, 1, 0, 0, 0, -1, 0};
    vt[4]  = '{"ch0_p32", 1'b1, 2'b01, 8'h20, 2'b00, 8'h7F,
               64, 0, 0, 0, 1, 0, 0, 0, -1, 0};
    vt[5]  = '{"ch0_brk_dt", 1'b1, 2'b10, 8'h20, 2'b00, 8'h7F,
               252, 252, 252, 4, 0, 0, 0, 0, -1, 0};
    vt[6]  = '{"ch0_max_dt", 1'b1, 2'b01, 8'h7F, 2'b00, 8'h7F,
               250, 0, 0, 4, 1, 0, 0, 0, -1, 0};
    vt[7]  = '{"ch0_zero", 1'b1, 2'b01, 8'h00, 2'b00, 8'h7F,
               0, 0, 0, -1, 1, 0, 0, 0, -1, 0};
    vt[8]  = '{"ch0_m1", 1'b1, 2'b01, 8'hFF, 2'b00, 8'h7F,
               0, 2, 0, 0, 1, 0, 0, 0, -1, 0};
    vt[9]  = '{"ch0_p1_dt", 1'b1, 2'b01, 8'h01, 2'b00, 8'h7F,
               0, 0, 0, -1, 1, 0, 0, 0, -1, 0};
    vt[10] = '{"ch0_p1", 1'b1, 2'b01, 8'h01, 2'b00, 8'h7F,
               2, 0, 0, 0, 1, 0, 0, 0, -1, 0};
    vt[11] = '{"disable", 1'b0, 2'b01, 8'h40, 2'b00, 8'h7F,
               0, 0, 0, -1, 0, 0, 0, 0, -1, 0};
    vt[12] = '{"reenable", 1'b1, 2'b01, 8'h40, 2'b00, 8'h7F,
               128, 0, 0, 0, 1, 0, 0, 0, -1, 0};

    set0(1'b1, 2'b01, 8'h40, 2'b00, 8'h00);
    bus1.enable   = 1'b1;
    bus1.mode     = 4'b0001;
    bus1.setpoint = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst.pwm_a", int'(bus0.pwm_a), 0);
    chk("rst.pwm_b", int'(bus0.pwm_b), 0);
    chk("rst.ps", int'(bus0.period_start), 0);
    chk("rst.at0", int'(bus0.at_target), 2);
    chk("rst.at1", int'(bus1.at_target), 3);
    reset_n = 1'b1;

    measure();
    check_ch("p1", 0, 0, 0, 0, 0, -1, 0);
    check_ch("p1", 0, 1, 0, 0, 0, -1, 1);
    check_ps("p1", 0);
    check_ps("p1", 1);
    measure();
    check_ch("p2", 0, 0, 128, 0, 0, 0, 1);
    check_ps("p2", 0);

    goto(100);
    bus0.setpoint[7:0] = 8'hC0;
    count_rest(255, n);
    chk("mid_change", n, 27);
    measure();
    check_ch("rev_dt", 0, 0, 0, 124, 0, 4, 1);
    measure();
    check_ch("rev", 0, 0, 0, 128, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      goto(100);
      set0(vt[i].en, vt[i].m0, vt[i].s0, vt[i].m1, vt[i].s1);
      measure();
      check_ch(vt[i].nm, 0, 0, vt[i].a0, vt[i].b0, vt[i].ab0,
               vt[i].f0, vt[i].t0);
      check_ch(vt[i].nm, 0, 1, vt[i].a1, vt[i].b1, vt[i].ab1,
               vt[i].f1, vt[i].t1);
      check_ps(vt[i].nm, 0);
    end

    goto(100);
    chk("en.pre", int'(bus0.pwm_a[0]), 1);
    bus0.enable = 1'b0;
    @(negedge clk);
    chk("en.off_a", int'(bus0.pwm_a[0]), 0);
    chk("en.off_b", int'(bus0.pwm_b[0]), 0);
    goto(110);
    bus0.enable = 1'b1;
    count_rest(255, n);
    chk("en.rest", n, 0);
    measure();
    check_ch("en.resume", 0, 0, 128, 0, 0, 0, 1);

    goto(50);
    chk("rst2.pre", int'(bus0.pwm_a[0]), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2.a", int'(bus0.pwm_a), 0);
    chk("rst2.b", int'(bus0.pwm_b), 0);
    chk("rst2.ps", int'(bus0.period_start), 0);
    reset_n = 1'b1;
    measure();
    check_ch("rst2.p1", 0, 0, 0, 0, 0, -1, 0);
    check_ch("rst2.p1", 0, 1, 0, 0, 0, -1, 0);
    check_ps("rst2.p1", 0);
    measure();
    check_ch("rst2.p2", 0, 0, 128, 0, 0, 0, 1);

    goto(100);
    bus1.setpoint[7:0] = 8'd100;
    for (int k = 0; k < 7; k++) begin
      measure();
      check_ch($sformatf("slew%0d", k), 1, 0,
               exp_a[k], 0, 0, 0, (k == 6) ? 1 : 0);
    end
    check_ch("slew_ch1", 1, 1, 0, 0, 0, -1, 1);
    goto(100);
    bus1.setpoint[7:0] = 8'h9C;
    measure();
    check_ch("slew_dn1", 1, 0, 168, 0, 0, 0, 0);
    measure();
    check_ch("slew_dn2", 1, 0, 136, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
